// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store initiator for a word-wide data memory.
// Loads are lane-selected and sign/zero-extended. Sub-word stores run a
// two-cycle read-modify-write. One request is in flight at a time, and there
// is a single registered response slot with valid/ready backpressure.
// Optional feature macro: LSU_SUBWORD_EN enables byte/half accesses. Without
// it, byte and half requests are answered with rsp_err and never touch memory.

module lsu_ctrl #(
  parameter int ADDR_LINE = 8,
  parameter int D_SIZE    = 32,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_LINE+1:0] req_addr,
  input  logic [D_SIZE-1:0]    req_wdata,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [D_SIZE-1:0]    rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_err,
  output logic                 mem_rw,
  output logic [ADDR_LINE-1:0] mem_addr,
  output logic [D_SIZE-1:0]    mem_wdata,
  input  logic [D_SIZE-1:0]    mem_rdata
);

  localparam logic [1:0] SZ_WORD = 2'b10;
`ifdef LSU_SUBWORD_EN
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic {IDLE, MERGE_WR} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t state_q, state_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [D_SIZE-1:0] rsp_data_q,  rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
  logic              rsp_err_q,   rsp_err_d;

`ifdef LSU_SUBWORD_EN
  logic [ADDR_LINE-1:0] merge_addr_q, merge_addr_d;
  logic [D_SIZE-1:0]    merge_data_q, merge_data_d;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [D_SIZE-1:0]    merged_word;
`endif

  logic                 req_fire;
  logic                 req_err;
  logic [ADDR_LINE-1:0] word_idx;
  logic [D_SIZE-1:0]    load_data;

  assign word_idx  = req_addr[ADDR_LINE+1:2];
  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

  // Flag misaligned or unsupported sizes so they are answered without a memory access
  always_comb begin
    req_err = 1'b1;
    case (req_size)
`ifdef LSU_SUBWORD_EN
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
`endif
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  // Pick the little-endian lane for loads and build the merged word for sub-word stores
  always_comb begin
    lane_byte   = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    lane_half   = mem_rdata[{req_addr[1], 4'b0000} +: 16];
    load_data   = mem_rdata;
    merged_word = mem_rdata;
    case (req_size)
      SZ_BYTE: begin
        load_data = {{(D_SIZE-8){lane_byte[7] & ~req_unsigned}}, lane_byte};
        merged_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{(D_SIZE-16){lane_half[15] & ~req_unsigned}}, lane_half};
        merged_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
      default: ;
    endcase
  end
`else
  logic unused_subword;
  assign load_data      = mem_rdata;
  assign unused_subword = req_unsigned;
`endif

  // Next-state, memory port drive and response-register update for every request kind
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    mem_rw       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
`ifdef LSU_SUBWORD_EN
    merge_addr_d = merge_addr_q;
    merge_data_d = merge_data_q;
`endif

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          rsp_tag_d = req_tag;
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else if (!req_we) begin
            mem_addr    = word_idx;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = load_data;
          end else if (req_size == SZ_WORD) begin
            mem_rw      = 1'b1;
            mem_addr    = word_idx;
            mem_wdata   = req_wdata;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end
`ifdef LSU_SUBWORD_EN
          else begin
            mem_addr     = word_idx;
            merge_addr_d = word_idx;
            merge_data_d = merged_word;
            state_d      = MERGE_WR;
          end
`endif
        end
      end
`ifdef LSU_SUBWORD_EN
      MERGE_WR: begin
        mem_rw      = 1'b1;
        mem_addr    = merge_addr_q;
        mem_wdata   = merge_data_q;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM state, response register and merge latches; reset drops any pending write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
`ifdef LSU_SUBWORD_EN
      merge_addr_q <= '0;
      merge_data_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
`ifdef LSU_SUBWORD_EN
      merge_addr_q <= merge_addr_d;
      merge_data_q <= merge_data_d;
`endif
    end
  end

endmodule
